// File: rtl/disp_wta.sv
// Winner-take-all disparity selector: tracks the lowest and second-lowest census cost
// streamed per disparity, and reports the winning disparity with a margin-based uniqueness flag.
module disp_wta #(
    parameter int COST_W   = 16,
    parameter int DISP_W   = 8,
    parameter int MAX_DISP = 64
) (
    input  logic        iClk,
    input  logic        iReset,
    input  logic        iClk_en,
    input  logic        iStart,
    input  logic [3:0]  iOp,
    input  logic [31:0] iA,
    input  logic [31:0] iB,
    output logic [31:0] oRes,
    output logic        oDone
);

    typedef enum logic [1:0] {S_IDLE, S_B1, S_B2, S_B3} state_t;
    typedef enum logic [2:0] {RES_HOLD, RES_ZERO, RES_RW, RES_DISP, RES_CNT} res_sel_t;

    function automatic logic [COST_W-1:0] f_ext8(input logic [7:0] b);
        logic [15:0] w;
        w = {8'd0, b};
        return w[COST_W-1:0];
    endfunction

    // Sum is one bit wider than a cost so best+margin never wraps past second.
    function automatic logic [31:0] f_rw(input logic [COST_W-1:0] best,
                                         input logic [COST_W-1:0] second,
                                         input logic [DISP_W-1:0] bdisp,
                                         input logic [15:0]       count,
                                         input logic [COST_W-1:0] margin,
                                         input logic              ovf);
        logic [COST_W:0] sum;
        logic            uniq;
        sum  = {1'b0, best} + {1'b0, margin};
        uniq = (count != 16'd0) && (sum < {1'b0, second});
        return {uniq, ovf, 6'd0, 8'(bdisp), 16'(best)};
    endfunction

    state_t            r_state, w_state_nx;
    res_sel_t          w_res_sel;
    logic [COST_W-1:0] r_best, r_second, r_margin;
    logic [COST_W-1:0] w_best_n, w_second_n, w_margin_n, w_cost;
    logic [DISP_W-1:0] r_best_disp, r_disp, w_best_disp_n, w_disp_n;
    logic [15:0]       r_count, w_count_n;
    logic              r_ovf, w_ovf_n;
    logic [23:0]       r_bytes;
    logic              w_push, w_clear, w_margin_ld, w_latch, w_done, w_room;
    logic [31:0]       w_rw;
    logic              w_unused;

    assign w_unused = ^iB;
    assign w_room   = {{(32-DISP_W){1'b0}}, r_disp} < 32'(MAX_DISP);

    always_comb begin
        w_state_nx  = r_state;
        w_push      = 1'b0;
        w_cost      = '0;
        w_clear     = 1'b0;
        w_margin_ld = 1'b0;
        w_latch     = 1'b0;
        w_res_sel   = RES_HOLD;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (iStart) begin
                    w_done = 1'b1;
                    case (iOp)
                        4'h0: begin w_clear = 1'b1; w_res_sel = RES_ZERO; end
                        4'h1: begin w_push = 1'b1; w_cost = iA[COST_W-1:0]; w_res_sel = RES_RW; end
                        4'h2: begin
                            w_push     = 1'b1;
                            w_cost     = f_ext8(iA[7:0]);
                            w_latch    = 1'b1;
                            w_done     = 1'b0;
                            w_state_nx = S_B1;
                        end
                        4'h3: begin w_margin_ld = 1'b1; w_res_sel = RES_RW; end
                        4'h4: w_res_sel = RES_RW;
                        4'h5: w_res_sel = RES_DISP;
                        4'h6: w_res_sel = RES_CNT;
                        default: ;
                    endcase
                end
            end
            S_B1: begin w_push = 1'b1; w_cost = f_ext8(r_bytes[7:0]);   w_state_nx = S_B2; end
            S_B2: begin w_push = 1'b1; w_cost = f_ext8(r_bytes[15:8]);  w_state_nx = S_B3; end
            S_B3: begin
                w_push     = 1'b1;
                w_cost     = f_ext8(r_bytes[23:16]);
                w_res_sel  = RES_RW;
                w_done     = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Strict compares: an equal cost never displaces the earlier (lower) disparity.
    always_comb begin
        w_best_n      = r_best;
        w_second_n    = r_second;
        w_best_disp_n = r_best_disp;
        w_disp_n      = r_disp;
        w_count_n     = r_count;
        w_ovf_n       = r_ovf;
        w_margin_n    = w_margin_ld ? iA[COST_W-1:0] : r_margin;
        if (w_clear) begin
            w_best_n      = '1;
            w_second_n    = '1;
            w_best_disp_n = '0;
            w_count_n     = '0;
            w_ovf_n       = 1'b0;
            w_disp_n      = iA[DISP_W-1:0];
        end else if (w_push) begin
            if (w_room) begin
                if (w_cost < r_best) begin
                    w_second_n    = r_best;
                    w_best_n      = w_cost;
                    w_best_disp_n = r_disp;
                end else if (w_cost < r_second) begin
                    w_second_n = w_cost;
                end
                w_disp_n  = r_disp + DISP_W'(1);
                w_count_n = r_count + 16'd1;
            end else begin
                w_ovf_n = 1'b1;
            end
        end
    end

    assign w_rw = f_rw(w_best_n, w_second_n, w_best_disp_n, w_count_n, w_margin_n, w_ovf_n);

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            r_state     <= S_IDLE;
            r_best      <= '1;
            r_second    <= '1;
            r_best_disp <= '0;
            r_disp      <= '0;
            r_count     <= '0;
            r_margin    <= '0;
            r_ovf       <= 1'b0;
            oRes        <= '0;
            oDone       <= 1'b0;
        end else if (iClk_en) begin
            r_state     <= w_state_nx;
            r_best      <= w_best_n;
            r_second    <= w_second_n;
            r_best_disp <= w_best_disp_n;
            r_disp      <= w_disp_n;
            r_count     <= w_count_n;
            r_margin    <= w_margin_n;
            r_ovf       <= w_ovf_n;
            oDone       <= w_done;
            case (w_res_sel)
                RES_ZERO: oRes <= '0;
                RES_RW:   oRes <= w_rw;
                RES_DISP: oRes <= {8'd0, 8'(r_disp), 16'(r_second)};
                RES_CNT:  oRes <= {16'd0, r_count};
                default:  ;
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (iClk_en && w_latch) r_bytes <= iA[31:8];
    end

endmodule

// File: tb/tb_disp_wta.sv
// Scoreboard bench for disp_wta: a sorted-multiset reference model predicts each result,
// and a monitor checks value and completion cycle whenever oDone pulses.
module tb_disp_wta;
    localparam int MAX_DISP = 64;

    logic        clk = 1'b0, rst_n = 1'b0, clk_en = 1'b1, start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = '0, b = '0, res;
    logic        done;

    disp_wta #(.COST_W(16), .DISP_W(8), .MAX_DISP(MAX_DISP)) dut (
        .iClk(clk), .iReset(rst_n), .iClk_en(clk_en), .iStart(start), .iOp(op),
        .iA(a), .iB(b), .oRes(res), .oDone(done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] res; int cyc; } exp_t;
    exp_t sb[$];
    int   n_cmp = 0, n_bad = 0, cyc = 0;
    logic prev_en = 1'b1;

    // Reference state: the list of accepted costs in disparity order.
    int          m_costs[$];
    int          m_start = 0, m_margin = 0;
    bit          m_ovf = 0;
    logic [31:0] m_last = '0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        prev_en <= clk_en;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void m_rank(output int best, output int second, output int bd);
        int s[$];
        int idx[$];
        s = m_costs;
        s.push_back(65535);
        s.push_back(65535);
        s.sort();
        best   = s[0];
        second = s[1];
        bd     = 0;
        if (best != 65535) begin
            idx = m_costs.find_first_index(x) with (x == best);
            bd  = m_start + idx[0];
        end
    endfunction

    function automatic logic [31:0] m_rw();
        int best, second, bd;
        bit uniq;
        m_rank(best, second, bd);
        uniq = (m_costs.size() != 0) && (best + m_margin < second);
        return {uniq, m_ovf, 6'd0, 8'(bd), 16'(best)};
    endfunction

    task automatic m_push(input int c);
        if (m_start + m_costs.size() < MAX_DISP) m_costs.push_back(c);
        else m_ovf = 1;
    endtask

    task automatic m_reset();
        m_costs.delete();
        m_start = 0; m_margin = 0; m_ovf = 0; m_last = '0;
    endtask

    task automatic m_apply(input int opc, input logic [31:0] av, output logic [31:0] r);
        int best, second, bd;
        r = m_last;
        case (opc)
            0: begin m_costs.delete(); m_start = int'(av[7:0]); m_ovf = 0; r = '0; end
            1: begin m_push(int'(av[15:0])); r = m_rw(); end
            2: begin
                for (int k = 0; k < 4; k++) m_push(int'((av >> (8 * k)) & 32'hFF));
                r = m_rw();
            end
            3: begin m_margin = int'(av[15:0]); r = m_rw(); end
            4: r = m_rw();
            5: begin m_rank(best, second, bd); r = {8'd0, 8'(m_start + m_costs.size()), 16'(second)}; end
            6: r = 32'(m_costs.size());
            default: ;
        endcase
        m_last = r;
    endtask

    task automatic issue(input int opc, input logic [31:0] av, input int stall);
        logic [31:0] r;
        int e0;
        @(negedge clk);
        start = 1'b1; op = 4'(opc); a = av; b = $urandom;
        e0 = cyc + 1;
        m_apply(opc, av, r);
        if (opc == 2) begin
            sb.push_back('{r, e0 + 3 + stall});
            @(negedge clk);
            op = 4'($urandom_range(0, 6)); a = $urandom;
            if (stall > 0) begin
                clk_en = 1'b0;
                repeat (stall) @(negedge clk);
                clk_en = 1'b1;
            end
            repeat (3) @(negedge clk);
            start = 1'b0;
        end else begin
            sb.push_back('{r, e0});
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic reset_mid_burst();
        @(negedge clk);
        start = 1'b1; op = 4'd2; a = $urandom;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        m_reset();
        @(negedge clk);
        chk("rst_burst_done", 32'(done), 32'd0);
        chk("rst_burst_res", res, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_burst_nodone", 32'(done), 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done && prev_en) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_done: got oDone=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("oRes", res, e.res);
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        logic [31:0] av;
        int opc;
        repeat (3) @(negedge clk);
        chk("reset_oDone", 32'(done), 32'd0);
        chk("reset_oRes", res, 32'd0);
        rst_n = 1'b1;
        m_reset();
        issue(4, 0, 0); issue(5, 0, 0); issue(6, 0, 0);
        issue(0, 0, 0); issue(3, 5, 0);
        issue(1, 40, 0); issue(1, 30, 0); issue(1, 50, 0); issue(1, 33, 0);
        issue(4, 0, 0); issue(5, 0, 0);
        issue(3, 3, 0); issue(4, 0, 0); issue(3, 2, 0); issue(4, 0, 0);
        issue(0, 10, 0); issue(2, 32'h14081408, 0); issue(4, 0, 0); issue(6, 0, 0); issue(5, 0, 0);
        issue(0, 62, 0); issue(1, 7, 0); issue(1, 5, 0); issue(1, 3, 0);
        issue(4, 0, 0); issue(6, 0, 0); issue(0, 0, 0); issue(4, 0, 0);
        issue(9, 32'hDEAD, 0); issue(15, 0, 0);
        reset_mid_burst();
        issue(4, 0, 0); issue(2, 32'h05030907, 0); issue(4, 0, 0);
        issue(0, 20, 0); issue(2, 32'h0A0B0C0D, 3); issue(4, 0, 0);
        issue(0, 60, 0); issue(2, 32'h04030201, 1); issue(6, 0, 0);
        for (int i = 0; i < 400; i++) begin
            av  = $urandom;
            opc = $urandom_range(0, 12);
            if (opc > 8) opc = 1;
            case (opc)
                0: av[7:0] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                          : 8'($urandom_range(0, 70));
                1: case ($urandom_range(0, 9))
                       0: av[15:0] = 16'hFFFF;
                       1: av[15:0] = 16'($urandom);
                       default: av[15:0] = 16'($urandom_range(0, 40));
                   endcase
                2: for (int k = 0; k < 4; k++) av[8*k +: 8] = 8'($urandom_range(0, 40));
                3: av[15:0] = 16'($urandom_range(0, 10));
                default: ;
            endcase
            issue(opc, av, (opc == 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
        end
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
